nrzi_tx_ctrl: RTL

- Transmit controller that sequences the NRZI line encoder.
- Accepts parallel words over a valid/ready handshake and serializes them MSB-first.
- Inserts a stuff bit (0) after STUFF_LEN consecutive 1s and drives the registered NRZI line.
- Sits between the word-producing logic and the serial line pin; owns the encoder line state, bit counting, burst framing and idle state.

---
 rtl/nrzi_tx_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nrzi_tx_ctrl.sv
// -----------------------------------------------------------------------------
// nrzi_tx_ctrl
//
// Transmit controller for an NRZI serial line. Parallel words arrive over a
// valid/ready handshake and are serialized MSB-first. After STUFF_LEN
// consecutive 1s a 0 is stuffed into the stream. The raw bit stream is NRZI
// encoded (1 = hold the line level, 0 = toggle it) and driven from a register.
//
// Parameters
//   WIDTH     : data word width in bits (>= 2)
//   STUFF_LEN : run of consecutive 1s that forces a stuffed 0 (>= 1)
//
// Ports
//   clock     : single clock, all state changes on the rising edge
//   reset_n   : asynchronous active-low reset
//   in_data   : word to transmit, MSB first; sampled only at the accept edge
//   in_valid  : in_data holds a word
//   in_ready  : controller can take a word this cycle (combinational)
//   line_out  : registered NRZI line, idles at 1
//   line_en   : registered, high while a data or stuff bit is on line_out
//   tx_bit    : registered raw (pre-NRZI) bit on the line, stuff bits included
//   word_done : one-cycle pulse while the last bit of a word (or the stuff
//               bit that bit triggered) is on the line
//   busy      : FSM is not idle
//   fsm_state : FSM state (0 = IDLE, 1 = SHIFT, 2 = STUFF) for observation
//
// Handshake: a word moves when in_valid and in_ready are both high at a rising
// clock edge. in_ready never depends on in_valid. A producer that sees
// in_ready low must hold in_valid and in_data unchanged until the transfer;
// nothing is consumed while in_ready is low.
// -----------------------------------------------------------------------------
module nrzi_tx_ctrl #(
  parameter int WIDTH     = 16,
  parameter int STUFF_LEN = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             line_out,
  output logic             line_en,
  output logic             tx_bit,
  output logic             word_done,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);

  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
  // ones_cnt never exceeds STUFF_LEN-1 while shifting, so matching this value
  // on a 1 bit is the same as ones_cnt+1 reaching STUFF_LEN.
  localparam logic [OW-1:0] STUFF_LAST = OW'(STUFF_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STUFF = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Datapath registers and their next values
  logic [WIDTH-1:0] shreg,     shreg_nxt;
  logic [BW-1:0]    bit_cnt,   bit_cnt_nxt;
  logic [OW-1:0]    ones_cnt,  ones_cnt_nxt;
  logic             word_end,  word_end_nxt;
  logic             line_nxt;
  logic             line_en_nxt;
  logic             tx_bit_nxt;
  logic             word_done_nxt;

  // Decode of the bit being shifted out this cycle
  logic cur_bit;
  logic last_bit;
  logic stuff_hit;
  logic accept;

  assign cur_bit   = shreg[WIDTH-1];
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign stuff_hit = cur_bit && (ones_cnt == STUFF_LAST);
  assign accept    = in_valid && in_ready;

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  // A new word can only be taken in a slot where the current one is finished
  // at this edge: idle, the last data bit when it does not trigger a stuff,
  // or the stuff bit that closes a word.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_SHIFT: in_ready = last_bit && !stuff_hit;
      S_STUFF: in_ready = word_end;
      default: in_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (stuff_hit) begin
          state_nxt = S_STUFF;
        end else if (last_bit) begin
          state_nxt = accept ? S_SHIFT : S_IDLE;
        end
      end
      S_STUFF: begin
        if (word_end) begin
          state_nxt = accept ? S_SHIFT : S_IDLE;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    ones_cnt_nxt  = ones_cnt;
    word_end_nxt  = word_end;
    line_nxt      = line_out;
    line_en_nxt   = line_en;
    tx_bit_nxt    = tx_bit;
    word_done_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        line_nxt     = 1'b1;
        line_en_nxt  = 1'b0;
        tx_bit_nxt   = 1'b1;
        ones_cnt_nxt = '0;
        word_end_nxt = 1'b0;
        if (accept) begin
          shreg_nxt   = in_data;
          bit_cnt_nxt = '0;
        end
      end

      S_SHIFT: begin
        // NRZI: a 1 holds the level, a 0 toggles it
        line_nxt     = cur_bit ? line_out : ~line_out;
        tx_bit_nxt   = cur_bit;
        line_en_nxt  = 1'b1;
        ones_cnt_nxt = cur_bit ? (ones_cnt + OW'(1)) : '0;
        shreg_nxt    = {shreg[WIDTH-2:0], 1'b0};
        // Counter saturates on the last bit; a reload restarts it below.
        bit_cnt_nxt  = last_bit ? bit_cnt : (bit_cnt + BW'(1));

        if (stuff_hit) begin
          // Remember whether the stuff bit is the tail of the word so the
          // STUFF slot knows to close it.
          word_end_nxt = last_bit;
        end else if (last_bit) begin
          word_done_nxt = 1'b1;
          if (accept) begin
            shreg_nxt   = in_data;
            bit_cnt_nxt = '0;
          end
        end
      end

      S_STUFF: begin
        // Stuffed bit is always 0, so the line always toggles
        line_nxt     = ~line_out;
        tx_bit_nxt   = 1'b0;
        line_en_nxt  = 1'b1;
        ones_cnt_nxt = '0;
        word_end_nxt = 1'b0;
        if (word_end) begin
          word_done_nxt = 1'b1;
          if (accept) begin
            shreg_nxt   = in_data;
            bit_cnt_nxt = '0;
          end
        end
      end

      default: begin
        line_nxt     = 1'b1;
        line_en_nxt  = 1'b0;
        tx_bit_nxt   = 1'b1;
        ones_cnt_nxt = '0;
        word_end_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      word_end  <= 1'b0;
      line_out  <= 1'b1;
      line_en   <= 1'b0;
      tx_bit    <= 1'b1;
      word_done <= 1'b0;
    end else begin
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ones_cnt  <= ones_cnt_nxt;
      word_end  <= word_end_nxt;
      line_out  <= line_nxt;
      line_en   <= line_en_nxt;
      tx_bit    <= tx_bit_nxt;
      word_done <= word_done_nxt;
    end
  end

endmodule
